// File: rtl/instr_mem_pkg.sv
// Shared types and sizing for the instruction-memory loader slice.
package instr_mem_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int IMEM_DEPTH     = 128;
  localparam int IMEM_ADDR_W    = 7;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/word_byte_serializer.sv
// Holds one captured 32-bit word and presents it MSB-first, one byte per advance.
module word_byte_serializer
  import instr_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        advance_i,
  input  logic [31:0] word_i,
  output logic [7:0]  byte_o,
  output logic        last_byte_o
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  byte_idx_q, byte_idx_d;

  // Shifting left keeps the outgoing byte in fixed flop bits, so byte_o needs no mux.
  always_comb begin
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    if (load_i) begin
      shift_d    = word_i;
      byte_idx_d = '0;
    end else if (advance_i) begin
      shift_d    = {shift_q[23:0], 8'h00};
      byte_idx_d = byte_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
    end else begin
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  assign byte_o      = shift_q[31:24];
  assign last_byte_o = (byte_idx_q == LAST_IDX);

endmodule

// File: rtl/instr_mem_loader.sv
// Loads 32-bit instruction words into the byte-wide instruction memory,
// big-endian, one byte per cycle, with overflow detection at the top address.
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int DEPTH     = IMEM_DEPTH,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  input  logic              word_last,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-2:0] word_count
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-2:0] CNT_ONE  = (ADDR_W - 1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-2:0] count_q, count_d;
  logic              last_q, last_d;
  logic              ovf_q, ovf_d;
  logic              ready_q, we_q, busy_q, done_q;

  logic              ser_load;
  logic              ser_advance;
  logic [7:0]        ser_byte;
  logic              ser_last_byte;

  word_byte_serializer u_serializer (
    .clk         (clk),
    .rst         (rst),
    .load_i      (ser_load),
    .advance_i   (ser_advance),
    .word_i      (word_data),
    .byte_o      (ser_byte),
    .last_byte_o (ser_last_byte)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    last_d      = last_q;
    ovf_d       = ovf_q;
    ser_load    = 1'b0;
    ser_advance = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = BASE;
          count_d = '0;
        end
      end

      LOAD: begin
        if (word_valid && ready_q) begin
          ser_load = 1'b0 | 1'b1;
          last_d   = word_last;
          state_d  = WRITE;
        end
      end

      // The final word of a session wins over overflow when both coincide.
      WRITE: begin
        ser_advance = 1'b1;
        addr_d      = addr_q + ADDR_ONE;
        if (ser_last_byte) begin
          count_d = count_q + CNT_ONE;
          if (last_q) begin
            state_d = DONE;
          end else if (addr_q == TOP_ADDR) begin
            state_d = DONE;
            ovf_d   = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end

      DONE: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = BASE;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so every output comes straight off a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= BASE;
      count_q <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      ready_q <= (state_d == LOAD);
      we_q    <= (state_d == WRITE);
      busy_q  <= (state_d == LOAD) || (state_d == WRITE);
      done_q  <= (state_d == DONE);
    end
  end

  assign word_ready = ready_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = ser_byte;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed sessions plus random traffic
// compared every cycle against a queue-based model of the expected byte writes.
module tb_instr_mem_loader;

  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;
  localparam int BASE   = 0;

  logic              clk;
  logic              rst;
  logic              start;
  logic              word_valid;
  logic [31:0]       word_data;
  logic              word_last;
  logic              word_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W-2:0] word_count;

  int tests  = 0;
  int failed = 0;

  instr_mem_loader #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_last  (word_last),
    .word_ready (word_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for the instruction memory so written bytes can be inspected later.
  logic [7:0] imem [DEPTH];
  always @(posedge clk) begin
    if (mem_we) imem[mem_addr] <= mem_wdata;
  end

  // Expected byte writes still outstanding, plus session-level bookkeeping.
  int         expAddr [$];
  logic [7:0] expData [$];
  bit         mActive    = 1'b0;
  bit         mFinished  = 1'b0;
  bit         mOvf       = 1'b0;
  bit         mLast      = 1'b0;
  bit         mJustReset = 1'b0;
  bit         mAccepted  = 1'b0;
  int         mCount     = 0;
  int         mNextAddr  = BASE;

  always @(posedge clk) begin
    mAccepted  = 1'b0;
    mJustReset = 1'b0;
    if (rst) begin
      mActive    = 1'b0;
      mFinished  = 1'b0;
      mOvf       = 1'b0;
      mCount     = 0;
      mNextAddr  = BASE;
      mJustReset = 1'b1;
      expAddr.delete();
      expData.delete();
    end else if (expAddr.size() > 0) begin
      int a;
      a = expAddr.pop_front();
      void'(expData.pop_front());
      if (expAddr.size() == 0) begin
        mCount++;
        if (mLast) begin
          mFinished = 1'b1;
        end else if (a == DEPTH - 1) begin
          mFinished = 1'b1;
          mOvf      = 1'b1;
        end
      end
    end else if (mActive && !mFinished) begin
      if (word_valid) begin
        for (int i = 0; i < 4; i++) begin
          expAddr.push_back(mNextAddr + i);
          expData.push_back(8'((word_data >> (24 - 8 * i)) & 32'hFF));
        end
        mNextAddr = mNextAddr + 4;
        mLast     = word_last;
        mAccepted = 1'b1;
      end
    end else if (start) begin
      mActive   = 1'b1;
      mFinished = 1'b0;
      mOvf      = 1'b0;
      mCount    = 0;
      mNextAddr = BASE;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    bit expReady;
    expReady = mActive && !mFinished && (expAddr.size() == 0);
    checkOutput("word_ready", int'(word_ready), int'(expReady));
    checkOutput("mem_we", int'(mem_we), int'(expAddr.size() > 0));
    checkOutput("busy", int'(busy), int'(mActive && !mFinished));
    checkOutput("done", int'(done), int'(mFinished));
    checkOutput("overflow", int'(overflow), int'(mOvf));
    checkOutput("word_count", int'(word_count), mCount);
    if (expAddr.size() > 0) begin
      checkOutput("mem_addr", int'(mem_addr), expAddr[0]);
      checkOutput("mem_wdata", int'(mem_wdata), int'(expData[0]));
    end
    if (expReady) checkOutput("loadAddr", int'(mem_addr), mNextAddr);
    if (mJustReset) begin
      checkOutput("rstAddr", int'(mem_addr), BASE);
      checkOutput("rstWdata", int'(mem_wdata), 0);
    end
  end

  task automatic applyStimulus(input bit s, input bit v, input logic [31:0] d,
                               input bit l, input bit r);
    start      = s;
    word_valid = v;
    word_data  = d;
    word_last  = l;
    rst        = r;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] prog2 [3];
  logic [31:0] fillWords [32];
  int          idx;
  int          readyCnt;
  int          cycles;

  initial begin
    #5000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    prog2[0] = 32'h20010005;
    prog2[1] = 32'h20020003;
    prog2[2] = 32'h00221820;

    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("resetReady", int'(word_ready), 0);
    checkOutput("resetWe", int'(mem_we), 0);
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetDone", int'(done), 0);
    checkOutput("resetCount", int'(word_count), 0);

    // Single-word program.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h8C220004, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("oneDone", int'(done), 1);
    checkOutput("oneCount", int'(word_count), 1);
    checkOutput("oneOvf", int'(overflow), 0);
    checkOutput("oneByte0", int'(imem[0]), 32'h8C);
    checkOutput("oneByte1", int'(imem[1]), 32'h22);
    checkOutput("oneByte2", int'(imem[2]), 32'h00);
    checkOutput("oneByte3", int'(imem[3]), 32'h04);

    // Back-to-back words with valid held high; start from DONE.
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("restartDone", int'(done), 0);
    checkOutput("restartReady", int'(word_ready), 1);
    checkOutput("restartAddr", int'(mem_addr), BASE);
    idx = 0; readyCnt = 0; cycles = 0;
    for (int c = 0; c < 40; c++) begin
      if (word_ready) readyCnt++;
      cycles++;
      applyStimulus(0, idx < 3, (idx < 3) ? prog2[idx] : 32'h0, idx == 2, 0);
      if (mAccepted) idx++;
      if (mFinished) break;
    end
    checkOutput("b2bDone", int'(done), 1);
    checkOutput("b2bReadyCycles", readyCnt, 3);
    checkOutput("b2bSessionCycles", cycles, 15);
    checkOutput("b2bCount", int'(word_count), 3);
    checkOutput("b2bByte4", int'(imem[4]), 32'h20);
    checkOutput("b2bByte7", int'(imem[7]), 32'h03);
    checkOutput("b2bByte10", int'(imem[10]), 32'h18);
    checkOutput("b2bByte11", int'(imem[11]), 32'h20);

    // Stall in LOAD with start pulses that must be ignored.
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(i % 3 == 0, 0, 32'hFFFF_FFFF, 0, 0);
    checkOutput("stallReady", int'(word_ready), 1);
    checkOutput("stallAddr", int'(mem_addr), BASE);
    applyStimulus(0, 1, $urandom, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("stallDone", int'(done), 1);

    // Fill all 128 bytes without ever signalling the last word.
    for (int i = 0; i < 32; i++) fillWords[i] = $urandom;
    applyStimulus(1, 0, 0, 0, 0);
    idx = 0;
    for (int c = 0; c < 600; c++) begin
      applyStimulus(0, (idx < 32) && ($urandom_range(0, 2) != 0),
                    (idx < 32) ? fillWords[idx] : 32'h0, 0, 0);
      if (mAccepted) idx++;
      if (mFinished) break;
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, $urandom, 0, 0);
    checkOutput("fillOvf", int'(overflow), 1);
    checkOutput("fillDone", int'(done), 1);
    checkOutput("fillCount", int'(word_count), 32);
    checkOutput("fillReady", int'(word_ready), 0);
    checkOutput("fillByte124", int'(imem[124]), int'(fillWords[31][31:24]));
    checkOutput("fillByte127", int'(imem[127]), int'(fillWords[31][7:0]));

    // Reset on the third write cycle of the second word.
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("clearOvf", int'(overflow), 0);
    checkOutput("clearDone", int'(done), 0);
    checkOutput("clearAddr", int'(mem_addr), BASE);
    applyStimulus(0, 1, 32'h11223344, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h55667788, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("midRstWe", int'(mem_we), 0);
    checkOutput("midRstBusy", int'(busy), 0);
    checkOutput("midRstCount", int'(word_count), 0);
    checkOutput("midRstAddr", int'(mem_addr), 0);
    checkOutput("keptByte4", int'(imem[4]), 32'h55);
    checkOutput("keptByte6", int'(imem[6]), 32'h77);
    checkOutput("untouchedByte7", int'(imem[7]), int'(fillWords[1][7:0]));
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'hDEADBEEF, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rewriteByte0", int'(imem[0]), 32'hDE);
    checkOutput("rewriteByte3", int'(imem[3]), 32'hEF);

    // Random traffic: gaps, early last, stray starts and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, $urandom,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 96) == 0);
    end
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
